// File: rtl/alu_control_seq_if.sv
// Upstream-facing bundle for the ALU control sequencer: request, flush and the
// registered decode/handshake results.
interface alu_control_seq_if #(
    parameter int ALUOP_W = 3,
    parameter int FUNCT_W = 6,
    parameter int CNT_W   = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [ALUOP_W-1:0] ALUOp;
    logic [FUNCT_W-1:0] funct;
    logic               flush;
    logic [CNT_W-1:0]   ALUCnt;
    logic               alu_start;
    logic               busy;
    logic               out_valid;
    logic               illegal;

    modport master (
        output in_valid, ALUOp, funct, flush,
        input  in_ready, ALUCnt, alu_start, busy, out_valid, illegal
    );

    modport slave (
        input  in_valid, ALUOp, funct, flush,
        output in_ready, ALUCnt, alu_start, busy, out_valid, illegal
    );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU control decode with MUL/DIV sequencing: single-cycle ops
// complete one cycle after accept, MUL/DIV hold busy until their latency expires.
module alu_control_seq #(
    parameter int ALUOP_W = 3,
    parameter int FUNCT_W = 6,
    parameter int CNT_W   = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_control_seq_if.slave    bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CTR_W   = $clog2(MAX_LAT);

    localparam logic [CNT_W-1:0] CODE_ADD = CNT_W'(4'b0000);
    localparam logic [CNT_W-1:0] CODE_SUB = CNT_W'(4'b0001);
    localparam logic [CNT_W-1:0] CODE_NOT = CNT_W'(4'b0010);
    localparam logic [CNT_W-1:0] CODE_LSL = CNT_W'(4'b0011);
    localparam logic [CNT_W-1:0] CODE_LSR = CNT_W'(4'b0100);
    localparam logic [CNT_W-1:0] CODE_AND = CNT_W'(4'b0101);
    localparam logic [CNT_W-1:0] CODE_OR  = CNT_W'(4'b0110);
    localparam logic [CNT_W-1:0] CODE_SLT = CNT_W'(4'b0111);
    localparam logic [CNT_W-1:0] CODE_MUL = CNT_W'(4'b1000);
    localparam logic [CNT_W-1:0] CODE_DIV = CNT_W'(4'b1001);
    localparam logic [CNT_W-1:0] CODE_ILL = CNT_W'(4'b1111);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CTR_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   alu_cnt_q, alu_cnt_d;
    logic               illegal_q, illegal_d;
    logic               alu_start_q, alu_start_d;
    logic               out_valid_q, out_valid_d;

    logic [CNT_W-1:0]   dec_code;
    logic               dec_illegal;
    logic               dec_multi;
    logic [CTR_W-1:0]   dec_load;
    logic               in_ready;
    logic               accept;

    // Zero-extending both fields makes any set bit above the architected width
    // fall through to the ILLEGAL default.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        dec_code  = CODE_ILL;
        dec_multi = 1'b0;
        dec_load  = '0;
        case (32'(bus.ALUOp))
            32'd0: begin
                case (32'(bus.funct))
                    32'd0:   dec_code = CODE_ADD;
                    32'd1:   dec_code = CODE_SUB;
                    32'd2:   dec_code = CODE_AND;
                    32'd3:   dec_code = CODE_OR;
                    32'd4:   dec_code = CODE_SLT;
                    32'd5:   dec_code = CODE_LSL;
                    32'd6:   dec_code = CODE_LSR;
                    32'd7:   dec_code = CODE_NOT;
                    32'd8: begin
                        dec_code  = CODE_MUL;
                        dec_multi = 1'b1;
                        dec_load  = CTR_W'(MUL_LAT - 2);
                    end
                    32'd9: begin
                        dec_code  = CODE_DIV;
                        dec_multi = 1'b1;
                        dec_load  = CTR_W'(DIV_LAT - 2);
                    end
                    default: dec_code = CODE_ILL;
                endcase
            end
            32'd1:   dec_code = CODE_SUB;
            32'd2:   dec_code = CODE_SLT;
            32'd3:   dec_code = CODE_ADD;
            32'd4:   dec_code = CODE_AND;
            32'd5:   dec_code = CODE_OR;
            default: dec_code = CODE_ILL;
        endcase
        dec_illegal = (dec_code == CODE_ILL);
    end

    assign in_ready = (state_q == IDLE) & ~bus.flush;
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_cnt_d   = alu_cnt_q;
        illegal_d   = illegal_q;
        alu_start_d = 1'b0;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_cnt_d = dec_code;
                    illegal_d = dec_illegal;
                    if (dec_multi) begin
                        state_d     = BUSY;
                        cnt_d       = dec_load;
                        alu_start_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                // Flush aborts silently; ALUCnt keeps the aborted op's code.
                if (bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_cnt_q   <= CODE_ADD;
            illegal_q   <= 1'b0;
            alu_start_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_cnt_q   <= alu_cnt_d;
            illegal_q   <= illegal_d;
            alu_start_q <= alu_start_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.ALUCnt    = alu_cnt_q;
    assign bus.illegal   = illegal_q;
    assign bus.alu_start = alu_start_q;
    assign bus.busy      = (state_q == BUSY);
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: decode table, MUL/DIV/flush/reset
// sequences, and randomized traffic against a cycle-level reference model.
module tb_alu_control_seq;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    localparam logic [3:0] R_TAB [10] = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7,
                                          4'h3, 4'h4, 4'h2, 4'h8, 4'h9};
    localparam logic [3:0] I_TAB [5]  = '{4'h1, 4'h7, 4'h0, 4'h5, 4'h6};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: remaining edges until out_valid (0 = idle).
    int         m_rem = 0;
    logic [3:0] m_code = 4'h0;
    logic       m_ill = 1'b0;
    logic       m_ov = 1'b0;
    logic       m_start = 1'b0;

    alu_control_seq_if #(.ALUOP_W(3), .FUNCT_W(6), .CNT_W(4)) bus ();

    alu_control_seq #(
        .ALUOP_W(3), .FUNCT_W(6), .CNT_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [2:0] op;
        logic [5:0] f;
        logic       fl;
        logic [3:0] exp_code;
        logic       exp_ill;
        logic       exp_ov;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [2:0] op, input logic [5:0] f,
                                       output logic [3:0] code, output int lat);
        code = 4'hF;
        lat  = 1;
        if (op == 3'd0) begin
            if (f < 6'd10) code = R_TAB[f[3:0]];
            if (code == 4'h8) lat = MUL_LAT;
            if (code == 4'h9) lat = DIV_LAT;
        end else if (op <= 3'd5) begin
            code = I_TAB[op - 3'd1];
        end
    endfunction

    function automatic void model_edge();
        logic [3:0] c;
        int         lat;
        if (!rst_n) begin
            m_rem = 0; m_code = 4'h0; m_ill = 1'b0; m_ov = 1'b0; m_start = 1'b0;
            return;
        end
        m_ov    = 1'b0;
        m_start = 1'b0;
        if (bus.flush) begin
            m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_ov = 1'b1;
        end else if (bus.in_valid) begin
            ref_decode(bus.ALUOp, bus.funct, c, lat);
            m_code = c;
            m_ill  = (c == 4'hF);
            if (lat > 1) begin
                m_rem   = lat - 1;
                m_start = 1'b1;
            end else begin
                m_ov = 1'b1;
            end
        end
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f, input logic fl);
        bus.in_valid = v;
        bus.ALUOp    = op;
        bus.funct    = f;
        bus.flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ALUCnt"},    32'(bus.ALUCnt),    32'(m_code));
        check({tag, ".illegal"},   32'(bus.illegal),   32'(m_ill));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_ov));
        check({tag, ".alu_start"}, 32'(bus.alu_start), 32'(m_start));
        check({tag, ".busy"},      32'(bus.busy),      32'(m_rem > 0));
    endtask

    task automatic check_ready(input string tag);
        #1;
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'((m_rem == 0) && !bus.flush));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 6'd0,  1'b0, 4'h0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 3'd0, 6'd1,  1'b0, 4'h1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 3'd0, 6'd2,  1'b0, 4'h5, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 3'd0, 6'd3,  1'b0, 4'h6, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 3'd0, 6'd4,  1'b0, 4'h7, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 3'd0, 6'd5,  1'b0, 4'h3, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 3'd0, 6'd6,  1'b0, 4'h4, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 3'd0, 6'd7,  1'b0, 4'h2, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 3'd0, 6'd63, 1'b0, 4'hF, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 3'd0, 6'd10, 1'b0, 4'hF, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 3'd1, 6'd33, 1'b0, 4'h1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 3'd2, 6'd0,  1'b0, 4'h7, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 3'd3, 6'd9,  1'b0, 4'h0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 3'd4, 6'd8,  1'b0, 4'h5, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 3'd5, 6'd1,  1'b0, 4'h6, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 3'd6, 6'd0,  1'b0, 4'hF, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 3'd3, 6'd0,  1'b1, 4'hF, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 3'd7, 6'd0,  1'b0, 4'hF, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 3'd1, 6'd0,  1'b0, 4'hF, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 3'd3, 6'd0,  1'b0, 4'h0, 1'b0, 1'b1};

        drive(1'b0, 3'd0, 6'd0, 1'b0);
        repeat (2) tick();
        check("reset.ALUCnt",    32'(bus.ALUCnt),    32'h0);
        check("reset.illegal",   32'(bus.illegal),   32'h0);
        check("reset.busy",      32'(bus.busy),      32'h0);
        check("reset.out_valid", 32'(bus.out_valid), 32'h0);
        check("reset.alu_start", 32'(bus.alu_start), 32'h0);
        check("reset.in_ready",  32'(bus.in_ready),  32'h1);
        rst_n = 1'b1;
        tick();

        // Decode table, applied back-to-back.
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].f, vecs[i].fl);
            #1;
            check($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(!vecs[i].fl));
            tick();
            check($sformatf("vec%0d.ALUCnt", i),    32'(bus.ALUCnt),    32'(vecs[i].exp_code));
            check($sformatf("vec%0d.illegal", i),   32'(bus.illegal),   32'(vecs[i].exp_ill));
            check($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d.busy", i),      32'(bus.busy),      32'h0);
        end
        drive(1'b0, 3'd0, 6'd0, 1'b0);
        tick();

        // DIV with a request held through busy.
        drive(1'b1, 3'd0, 6'd9, 1'b0);
        tick();
        drive(1'b1, 3'd3, 6'd0, 1'b0);
        check("div.alu_start1", 32'(bus.alu_start), 32'h1);
        for (int k = 1; k <= DIV_LAT - 1; k++) begin
            check($sformatf("div.busy_t%0d", k),   32'(bus.busy),      32'h1);
            check($sformatf("div.ov_t%0d", k),     32'(bus.out_valid), 32'h0);
            check($sformatf("div.code_t%0d", k),   32'(bus.ALUCnt),    32'h9);
            check($sformatf("div.ready_t%0d", k),  32'(bus.in_ready),  32'h0);
            tick();
            if (k == 1) check("div.alu_start2", 32'(bus.alu_start), 32'h0);
        end
        check("div.ov_final",    32'(bus.out_valid), 32'h1);
        check("div.busy_final",  32'(bus.busy),      32'h0);
        check("div.code_final",  32'(bus.ALUCnt),    32'h9);
        check("div.ready_final", 32'(bus.in_ready),  32'h1);
        tick();
        check("div.held_add_code", 32'(bus.ALUCnt),    32'h0);
        check("div.held_add_ov",   32'(bus.out_valid), 32'h1);
        drive(1'b0, 3'd0, 6'd0, 1'b0);
        tick();

        // MUL flushed in its second busy cycle, then an ADD.
        drive(1'b1, 3'd0, 6'd8, 1'b0);
        tick();
        check("mul.alu_start", 32'(bus.alu_start), 32'h1);
        check("mul.code",      32'(bus.ALUCnt),    32'h8);
        drive(1'b0, 3'd0, 6'd0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 6'd0, 1'b1);
        tick();
        drive(1'b1, 3'd3, 6'd0, 1'b0);
        #1;
        check("flush.busy",     32'(bus.busy),      32'h0);
        check("flush.ov",       32'(bus.out_valid), 32'h0);
        check("flush.in_ready", 32'(bus.in_ready),  32'h1);
        check("flush.code",     32'(bus.ALUCnt),    32'h8);
        tick();
        check("flush.add_ov",   32'(bus.out_valid), 32'h1);
        check("flush.add_code", 32'(bus.ALUCnt),    32'h0);
        drive(1'b0, 3'd0, 6'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("flush.quiet%0d", k), 32'(bus.out_valid), 32'h0);
        end

        // Asynchronous reset in the first cycle of a DIV.
        drive(1'b1, 3'd0, 6'd9, 1'b0);
        tick();
        drive(1'b0, 3'd0, 6'd0, 1'b0);
        check("rst.pre_start", 32'(bus.alu_start), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.ALUCnt",    32'(bus.ALUCnt),    32'h0);
        check("rst.busy",      32'(bus.busy),      32'h0);
        check("rst.alu_start", 32'(bus.alu_start), 32'h0);
        check("rst.out_valid", 32'(bus.out_valid), 32'h0);
        check("rst.in_ready",  32'(bus.in_ready),  32'h1);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("rst.quiet_ov%0d", k),   32'(bus.out_valid), 32'h0);
            check($sformatf("rst.quiet_busy%0d", k), 32'(bus.busy),      32'h0);
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic [2:0] op;
            logic [5:0] f;
            op = ($urandom % 2 == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            f  = ($urandom % 4 != 0) ? 6'($urandom_range(0, 9)) : 6'($urandom);
            drive(($urandom % 3) != 0, op, f, ($urandom % 12) == 0);
            check_ready($sformatf("rnd%0d", n));
            tick();
            check_model($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Parametrised, registered successor to the combinational ALU control decode.
- Maps ALUOp/funct to a 4-bit ALU control code, adds MUL/DIV, and flags illegal encodings instead of driving X.
- Sequences the multi-cycle MUL/DIV ops with a valid/ready handshake and a busy/stall output.
- Sits between the main control unit and the ALU; the pipeline stalls on busy.

Parameters:
- ALUOP_W, 3, width of the ALUOp input.
- FUNCT_W, 6, width of the funct field.
- CNT_W, 4, width of the ALU control output.
- MUL_LAT, 4, total cycles for MUL from accept to out_valid; must be >= 2.
- DIV_LAT, 8, total cycles for DIV from accept to out_valid; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALUOp/funct are valid this cycle.
- in_ready  output  1  block can accept; equals (state==IDLE) & ~flush.
- ALUOp  input  ALUOP_W  operation class from main control.
- funct  input  FUNCT_W  R-type function field.
- flush  input  1  synchronous abort of the op in flight.
- ALUCnt  output  CNT_W  registered ALU control code.
- alu_start  output  1  one-cycle pulse on the first cycle of a MUL/DIV.
- busy  output  1  multi-cycle op in flight; pipeline stall request.
- out_valid  output  1  one-cycle pulse: ALUCnt is final for the accepted op.
- illegal  output  1  registered with ALUCnt; accepted encoding was unsupported.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, ALUCnt=0000, alu_start=0, busy=0, out_valid=0, illegal=0. in_ready=1 once flush is low.
- Codes: ADD 0000, SUB 0001, NOT 0010, LSL 0011, LSR 0100, AND 0101, OR 0110, SLT 0111, MUL 1000, DIV 1001, ILLEGAL 1111.
- ALUOp=000 (R-type), decoded by funct:
  - 000000 ADD, 000001 SUB, 000010 AND, 000011 OR, 000100 SLT.
  - 000101 LSL, 000110 LSR, 000111 NOT.
  - 001000 MUL, 001001 DIV; any other funct -> ILLEGAL.
- ALUOp 001 -> SUB (BEQ); 010 -> SLT (SLTI); 011 -> ADD (ADDI/LW/SW); 100 -> AND (ANDI); 101 -> OR (ORI); 110/111 -> ILLEGAL.
- ALUOp is zero-extended/compared at ALUOP_W; bits above 3 nonzero -> ILLEGAL.
- Accept: in_valid & in_ready at a rising edge. ALUCnt and illegal are registered on that edge and held until the next accept.
- Single-cycle op (incl. ILLEGAL):
  - out_valid=1 in the cycle after accept (latency 1); stay IDLE.
  - Back-to-back accepts every cycle are allowed.
- MUL/DIV:
  - On accept go to BUSY; counter=LAT-2; alu_start=1 and busy=1 in the cycle after accept.
  - In BUSY the counter decrements each cycle. When it is 0, next state is IDLE with out_valid=1.
  - out_valid therefore rises exactly LAT cycles after the accept edge.
  - busy=1 for LAT-1 cycles, deasserting in the out_valid cycle. in_ready=1 again in the out_valid cycle (back-to-back permitted).
- Only one op in flight. in_valid during BUSY is ignored (not accepted); the upstream holds it.
- flush:
  - In BUSY: next state IDLE, counter=0, busy=0, no out_valid; ALUCnt holds.
  - flush with in_valid in IDLE: the request is not accepted and any pending single-cycle out_valid is suppressed.
  - flush wins over every simultaneous event.
- Reset mid-op: immediate return to reset values; no out_valid.
- Counter width is clog2(max(MUL_LAT,DIV_LAT)); no wrap occurs because the counter is only reloaded on accept.

Test Plan:
- Reset, then ALUOp=000 funct=000010 with in_valid one cycle -> next cycle ALUCnt=0101, out_valid=1, illegal=0, in_ready stays 1.
- Back-to-back accepts ALUOp=001, 010, 011, 100 -> out_valid high 4 consecutive cycles; ALUCnt 0001, 0111, 0000, 0101.
- ALUOp=000 funct=001001 (DIV_LAT=8) -> alu_start pulse at t+1; busy t+1..t+7; out_valid at t+8 with ALUCnt=1001; in_valid held during busy is not accepted until t+8.
- ALUOp=000 funct=111111, then ALUOp=111 -> each yields ALUCnt=1111, illegal=1, out_valid=1, no X on any output.
- MUL accepted, flush asserted at t+2 -> busy=0 and in_ready=1 at t+3; no out_valid within 10 cycles; a new ADD accepted at t+3 completes at t+4.
- rst_n low asynchronously mid-DIV -> all outputs return to reset values before the next clock edge; no out_valid after release.
